spi_slave_regfile: RTL

//  Parametrised SPI slave register file, successor to the fixed 4x8-bit mode-0 slave.
//  - Supports all four SPI modes, a configurable register width and register count.
//  - Supports multi-word burst read/write with address auto-increment and wrap.
//  - Exposes all registers to local logic and pulses a write strobe per committed word.

---
 rtl/spi_slv_pkg.sv | 23 ++
 rtl/spi_slv_shifter.sv | 106 ++++++++++
 rtl/spi_slave_regfile.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/spi_slv_pkg.sv
// Shared types and constants for the SPI slave register file.
//   state_t         frame-level FSM states
//   CMD_W           command byte length in bits
//   CMD_WR_BIT      command bit selecting write (1) or read (0)
//   sample_on_rise  1 when mosi is sampled on the rising sclk edge
package spi_slv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WR_DATA = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  localparam int CMD_W      = 8;
  localparam int CMD_WR_BIT = 7;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_slv_shifter.sv
// SPI bit engine: input synchronisers, sclk edge detection, receive shifter,
// transmit shifter and bit counter.
// Ports:
//   clk, reset         system clock, async active-high reset
//   sclk, mosi, ss_n   raw SPI pins (asynchronous to clk)
//   cmd_phase          1 while the command byte is being received (8-bit word)
//   tx_load, tx_word   load a new word into the transmit shifter
//   ss_sync            synchronised ss_n
//   ss_fall            1-cycle pulse on synchronised ss_n falling edge
//   word_done          1-cycle pulse once a complete word is in rx_word
//   rx_word            received word (command byte sits in the low 8 bits)
//   tx_bit             current transmit bit (MSB of the transmit shifter)
module spi_slv_shifter
  import spi_slv_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CPOL = 0,
  parameter int CPHA = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sclk,
  input  logic          mosi,
  input  logic          ss_n,
  input  logic          cmd_phase,
  input  logic          tx_load,
  input  logic [DW-1:0] tx_word,
  output logic          ss_sync,
  output logic          ss_fall,
  output logic          word_done,
  output logic [DW-1:0] rx_word,
  output logic          tx_bit
);

  localparam logic IDLE_LVL = (CPOL != 0);
  localparam logic S_RISE   = sample_on_rise(CPOL != 0, CPHA != 0);

  // [0] metastability stage, [1] synchronised value, [2] previous synchronised value
  logic [2:0]    sclk_r;
  logic [1:0]    mosi_r;
  logic [2:0]    ss_r;
  logic [DW-1:0] rx;
  logic [DW-1:0] tx;
  logic [5:0]    cnt;
  logic          fresh;
  logic          rise, fall, sample, shift, last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_r <= {3{IDLE_LVL}};
      mosi_r <= '0;
      ss_r   <= '1;
    end else begin
      sclk_r <= {sclk_r[1:0], sclk};
      mosi_r <= {mosi_r[0], mosi};
      ss_r   <= {ss_r[1:0], ss_n};
    end
  end

  assign ss_sync = ss_r[1];
  assign ss_fall = ~ss_r[1] & ss_r[2];
  assign rise    = sclk_r[1] & ~sclk_r[2];
  assign fall    = ~sclk_r[1] & sclk_r[2];
  assign sample  = ~ss_sync & (S_RISE ? rise : fall);
  assign shift   = ~ss_sync & (S_RISE ? fall : rise);
  assign last    = (cnt == (cmd_phase ? 6'(CMD_W - 1) : 6'(DW - 1)));

  // A freshly loaded word must survive the first shift edge after the load so
  // its MSB is on miso for the next sample edge; that edge only clears 'fresh'.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx        <= '0;
      tx        <= '0;
      cnt       <= '0;
      fresh     <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (ss_sync) begin
        cnt   <= '0;
        fresh <= 1'b0;
      end else begin
        if (sample) begin
          rx <= {rx[DW-2:0], mosi_r[1]};
          if (last) begin
            cnt       <= '0;
            word_done <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        if (tx_load) begin
          tx    <= tx_word;
          fresh <= 1'b1;
        end else if (shift) begin
          if (fresh) fresh <= 1'b0;
          else       tx    <= {tx[DW-2:0], 1'b0};
        end
      end
    end
  end

  assign rx_word = rx;
  assign tx_bit  = tx[DW-1];

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave register file: NREG registers of DW bits, burst read/write with
// address auto-increment and wrap, any SPI mode (CPOL/CPHA).
// Optional feature macro: SPI_SLV_IRQ_EN adds a sticky write interrupt
// (irq_o, cleared by irq_clr_i; a write in the same cycle wins over clear).
// Ports:
//   clk, reset          system clock, async active-high reset
//   sclk, mosi, ss_n    SPI slave pins, miso tri-stated while ss_n is high
//   regs_o              flat register image, reg k at [k*DW +: DW]
//   wr_pulse_o          1-cycle strobe per committed write word
//   wr_addr_o           address of the last committed word
//   busy_o              frame in progress
//   irq_o, irq_clr_i    write interrupt (SPI_SLV_IRQ_EN only)
//
// state   | meaning
// IDLE    | no frame, waiting for ss_n to fall
// CMD     | receiving the 8-bit command byte
// WR_DATA | receiving data words, each committed to reg[addr]
// RD_DATA | transmitting reg[addr] words on miso
module spi_slave_regfile
  import spi_slv_pkg::*;
#(
  parameter int            DW      = 8,
  parameter int            NREG    = 4,
  parameter int            CPOL    = 0,
  parameter int            CPHA    = 0,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sclk,
  input  logic                      mosi,
  input  logic                      ss_n,
  output logic                      miso,
  output logic [NREG*DW-1:0]        regs_o,
  output logic                      wr_pulse_o,
  output logic [$clog2(NREG)-1:0]   wr_addr_o,
  output logic                      busy_o
`ifdef SPI_SLV_IRQ_EN
  ,
  output logic                      irq_o,
  input  logic                      irq_clr_i
`endif
);

  localparam int ADDR_W = $clog2(NREG);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt, ld_addr;
  logic [DW-1:0]       regs [NREG];
  logic [DW-1:0]       rx_word, tx_word;
  logic                ss_sync, ss_fall, word_done, tx_bit;
  logic                tx_load, wr_en, cmd_phase;

  assign cmd_phase = (state == IDLE) || (state == CMD);

  spi_slv_shifter #(
    .DW   (DW),
    .CPOL (CPOL),
    .CPHA (CPHA)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .cmd_phase (cmd_phase),
    .tx_load   (tx_load),
    .tx_word   (tx_word),
    .ss_sync   (ss_sync),
    .ss_fall   (ss_fall),
    .word_done (word_done),
    .rx_word   (rx_word),
    .tx_bit    (tx_bit)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    ld_addr   = addr;
    tx_load   = 1'b0;
    wr_en     = 1'b0;
    if (ss_sync) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (ss_fall) state_nxt = CMD;
        CMD: if (word_done) begin
          addr_nxt = rx_word[ADDR_W-1:0];
          ld_addr  = rx_word[ADDR_W-1:0];
          if (rx_word[CMD_WR_BIT]) begin
            state_nxt = WR_DATA;
          end else begin
            state_nxt = RD_DATA;
            tx_load   = 1'b1;
          end
        end
        WR_DATA: if (word_done) begin
          wr_en    = 1'b1;
          addr_nxt = addr + ADDR_W'(1);
        end
        RD_DATA: if (word_done) begin
          addr_nxt = addr + ADDR_W'(1);
          ld_addr  = addr + ADDR_W'(1);
          tx_load  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Reload reads the live array, so a word written earlier in the frame is seen.
  assign tx_word = regs[ld_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      wr_pulse_o <= 1'b0;
      wr_addr_o  <= '0;
      for (int k = 0; k < NREG; k++) regs[k] <= RST_VAL;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      wr_pulse_o <= wr_en;
      if (wr_en) begin
        regs[addr] <= rx_word;
        wr_addr_o  <= addr;
      end
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_img
    assign regs_o[k*DW +: DW] = regs[k];
  end

  assign busy_o = (state != IDLE);
  assign miso   = ss_sync ? 1'bz : ((state == RD_DATA) ? tx_bit : 1'b0);

`ifdef SPI_SLV_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          irq_o <= 1'b0;
    else if (wr_pulse_o) irq_o <= 1'b1;
    else if (irq_clr_i) irq_o <= 1'b0;
  end
`endif

endmodule
